// File: rtl/iw_pkg.sv
// Shared types for the instruction-wait queue: exception field widths,
// per-slot status record and the pointer-width helper.
package iw_pkg;

    localparam int ECODE_W = 6;
    localparam int ESUB_W  = 9;

    // Status half of a queue slot; pc and inst are stored alongside it
    // in the slot RAM so their widths can follow the top-level parameters.
    typedef struct packed {
        logic               filled;
        logic               req_pending;
        logic               exc;
        logic [ECODE_W-1:0] ecode;
        logic [ESUB_W-1:0]  esubcode;
    } iw_slot_t;

    function automatic int iw_ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/iw_slot_ram.sv
// DEPTH-entry slot storage: push write port at the tail, fill write port
// for returning responses, asynchronous read of the head slot.
module iw_slot_ram
    import iw_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    localparam int PW    = iw_ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_en,
    input  logic [PW-1:0]     push_idx,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [DATA_W-1:0] push_inst,
    input  iw_slot_t          push_slot,
    input  logic              fill_en,
    input  logic [PW-1:0]     fill_idx,
    input  logic [DATA_W-1:0] fill_inst,
    input  logic [PW-1:0]     head_idx,
    output logic [PC_W-1:0]   head_pc,
    output logic [DATA_W-1:0] head_inst,
    output iw_slot_t          head_slot,
    output logic [DEPTH-1:0]  pend_vec
);

    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    iw_slot_t          slot_q [DEPTH];

    // Push writes a whole slot; fill retires the request and keeps data already present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
                slot_q[i] <= '0;
            end
        end else begin
            if (push_en) begin
                pc_q[push_idx]   <= push_pc;
                inst_q[push_idx] <= push_inst;
                slot_q[push_idx] <= push_slot;
            end
            if (fill_en) begin
                slot_q[fill_idx].req_pending <= 1'b0;
                if (!slot_q[fill_idx].filled) begin
                    inst_q[fill_idx]        <= fill_inst;
                    slot_q[fill_idx].filled <= 1'b1;
                end
            end
        end
    end

    // Expose the outstanding-request flag of every slot for the fill scan.
    always_comb begin
        pend_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_vec[i] = slot_q[i].req_pending;
        end
    end

    assign head_pc   = pc_q[head_idx];
    assign head_inst = inst_q[head_idx];
    assign head_slot = slot_q[head_idx];

endmodule

// File: rtl/iw_queue.sv
// Instruction-wait queue between IF and ID: DEPTH in-order slots, multiple
// outstanding in-order instruction responses, flush with late-response
// discard counter. Optional macro IW_QUEUE_BYPASS_EN forwards a response
// aimed at the head slot to the output in the same cycle.
module iw_queue
    import iw_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   br_flush,
    input  logic                   ex_flush,
    input  logic                   ertn_flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   in_req_sent,
    input  logic                   in_inst_valid,
    input  logic [DATA_W-1:0]      in_inst,
    input  logic                   in_has_exception,
    input  logic [5:0]             in_ecode,
    input  logic [8:0]             in_esubcode,
    input  logic                   data_ok,
    input  logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] req_credit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [DATA_W-1:0]      out_inst,
    output logic                   out_has_exception,
    output logic [5:0]             out_ecode,
    output logic [8:0]             out_esubcode
);

    localparam int PW = iw_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush, push, pop, not_empty;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, fill_ptr, scan_idx;
    logic [CW-1:0]     count_q, count_d, disc_q, disc_d, pend_cnt;
    logic              fill_found, resp_to_slot, resp_to_head, bypass;
    logic              fill_en, pop_orphan;
    logic [DEPTH-1:0]  pend_vec, live_vec;
    logic [PC_W-1:0]   head_pc;
    logic [DATA_W-1:0] head_inst;
    iw_slot_t          head_slot, push_slot;

    iw_slot_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) u_ram (
        .clk       (clk),
        .rst_n     (resetn),
        .push_en   (push),
        .push_idx  (tail_q),
        .push_pc   (in_pc),
        .push_inst (in_inst),
        .push_slot (push_slot),
        .fill_en   (fill_en),
        .fill_idx  (fill_ptr),
        .fill_inst (rdata),
        .head_idx  (head_q),
        .head_pc   (head_pc),
        .head_inst (head_inst),
        .head_slot (head_slot),
        .pend_vec  (pend_vec)
    );

    // Build the incoming slot; a request sent alongside valid data still owns a response.
    always_comb begin
        push_slot             = '0;
        push_slot.filled      = in_inst_valid || in_has_exception;
        push_slot.req_pending = in_req_sent;
        push_slot.exc         = in_has_exception;
        push_slot.ecode       = in_ecode;
        push_slot.esubcode    = in_esubcode;
    end

    // Mark live slots and count the live ones still waiting for a response.
    always_comb begin
        live_vec = '0;
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_vec[i] = {1'b0, PW'(i) - head_q} < count_q;
            pend_cnt    = pend_cnt + CW'(live_vec[i] & pend_vec[i]);
        end
    end

    // Oldest live pending slot, scanned from head; lowest offset wins.
    always_comb begin
        fill_ptr   = head_q;
        fill_found = 1'b0;
        scan_idx   = head_q;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            scan_idx = head_q + PW'(k);
            if (live_vec[scan_idx] && pend_vec[scan_idx]) begin
                fill_ptr   = scan_idx;
                fill_found = 1'b1;
            end
        end
    end

    assign flush        = br_flush || ex_flush || ertn_flush;
    assign not_empty    = (count_q != '0);
    assign resp_to_slot = data_ok && (disc_q == '0) && fill_found;
    assign resp_to_head = resp_to_slot && (fill_ptr == head_q);

`ifdef IW_QUEUE_BYPASS_EN
    assign bypass = not_empty && !head_slot.filled && head_slot.req_pending && resp_to_head;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid  = not_empty && !flush && (head_slot.filled || bypass);
    assign pop        = out_valid && out_ready;
    assign in_ready   = resetn && !flush && (count_q < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    // A bypassed head that pops this cycle needs no write-back.
    assign fill_en    = resp_to_slot && !flush && !(bypass && pop);
    // Popping a slot whose response is still in flight hands that response to the discard counter.
    assign pop_orphan = pop && head_slot.req_pending && !resp_to_head;
    assign req_credit = CW'(DEPTH) - disc_q - pend_cnt;

    assign out_pc            = not_empty ? head_pc : '0;
    assign out_inst          = bypass ? rdata : (not_empty ? head_inst : '0);
    assign out_has_exception = not_empty && head_slot.exc;
    assign out_ecode         = not_empty ? head_slot.ecode : '0;
    assign out_esubcode      = not_empty ? head_slot.esubcode : '0;

    // Pointer, occupancy and discard-counter next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        disc_d  = disc_q;
        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
            if (data_ok && ((disc_q + pend_cnt) != '0)) begin
                disc_d = disc_q + pend_cnt - CW'(1);
            end else begin
                disc_d = disc_q + pend_cnt;
            end
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            disc_d  = disc_q - CW'(data_ok && (disc_q != '0)) + CW'(pop_orphan);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            disc_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            disc_q  <= disc_d;
        end
    end

endmodule

// File: tb/tb_iw_queue.sv
// Bench for iw_queue: directed scenarios followed by random traffic, all
// checked against a slot-list / response-tag reference model.
module tb_iw_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        br_flush, ex_flush, ertn_flush;
    logic        in_valid, in_ready;
    logic [31:0] in_pc;
    logic        in_req_sent, in_inst_valid;
    logic [31:0] in_inst;
    logic        in_has_exception;
    logic [5:0]  in_ecode;
    logic [8:0]  in_esubcode;
    logic        data_ok;
    logic [31:0] rdata;
    logic [2:0]  req_credit;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst;
    logic        out_has_exception;
    logic [5:0]  out_ecode;
    logic [8:0]  out_esubcode;

    always #5 clk = ~clk;

    iw_queue #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .br_flush(br_flush), .ex_flush(ex_flush), .ertn_flush(ertn_flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_req_sent(in_req_sent), .in_inst_valid(in_inst_valid), .in_inst(in_inst),
        .in_has_exception(in_has_exception), .in_ecode(in_ecode), .in_esubcode(in_esubcode),
        .data_ok(data_ok), .rdata(rdata), .req_credit(req_credit),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_has_exception(out_has_exception), .out_ecode(out_ecode), .out_esubcode(out_esubcode)
    );

    // Reference model: queued slots in program order, plus the in-order list of
    // outstanding responses tagged with the slot they were requested for.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
        bit          exc;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        int          id;
    } mslot_t;

    mslot_t mq[$];
    int     rq[$];
    int     next_id = 1;
    int     n_pass = 0;
    int     n_fail = 0;
    int     n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_bypass();
`ifdef IW_QUEUE_BYPASS_EN
        return (mq.size() > 0) && !mq[0].filled && data_ok && (rq.size() > 0) && (rq[0] == mq[0].id);
`else
        return 1'b0;
`endif
    endfunction

    task automatic clr();
        br_flush = 0; ex_flush = 0; ertn_flush = 0;
        in_valid = 0; in_pc = '0; in_req_sent = 0; in_inst_valid = 0; in_inst = '0;
        in_has_exception = 0; in_ecode = '0; in_esubcode = '0;
        data_ok = 0; rdata = '0; out_ready = 0;
    endtask

    task automatic set_push(input logic [31:0] pc, input bit req, input bit iv, input logic [31:0] inst);
        in_valid = 1; in_pc = pc; in_req_sent = req; in_inst_valid = iv; in_inst = iv ? inst : 32'h0;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        bit flush, byp, m_ir, m_ov, pop, push;
        flush = br_flush | ex_flush | ertn_flush;
        byp   = m_bypass();
        m_ir  = (mq.size() < DEPTH) && !flush;
        m_ov  = (mq.size() > 0) && !flush && (mq[0].filled || byp);
        @(negedge clk);
        chk("in_ready", in_ready, m_ir);
        chk("out_valid", out_valid, m_ov);
        chk("req_credit", req_credit, DEPTH - rq.size());
        if (mq.size() > 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            if (m_ov) begin
                chk("out_inst", out_inst, byp ? rdata : mq[0].inst);
                chk("out_exc", out_has_exception, mq[0].exc);
                chk("out_ecode", out_ecode, mq[0].ecode);
                chk("out_esub", out_esubcode, mq[0].esub);
            end
        end else begin
            chk("out_pc_empty", out_pc, 0);
            chk("out_inst_empty", out_inst, 0);
        end
        pop  = m_ov && out_ready;
        push = in_valid && m_ir;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            if (data_ok) void'(rq.pop_front());
        end else begin
            if (data_ok) begin
                int t;
                t = rq.pop_front();
                foreach (mq[j]) begin
                    if (mq[j].id == t && !mq[j].filled) begin
                        mq[j].inst   = rdata;
                        mq[j].filled = 1;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                mslot_t s;
                s.pc = in_pc; s.inst = in_inst;
                s.filled = in_inst_valid || in_has_exception;
                s.exc = in_has_exception; s.ecode = in_ecode; s.esub = in_esubcode;
                s.id = next_id++;
                mq.push_back(s);
                if (in_req_sent) rq.push_back(s.id);
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && (mq.size() > 0 || rq.size() > 0); i++) begin
            clr();
            out_ready = 1;
            data_ok = (rq.size() > 0);
            rdata = $urandom;
            cyc();
        end
        clr();
        chk("drain_credit", req_credit, DEPTH);
        chk("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_credit", req_credit, DEPTH);
        chk("rst_out_pc", out_pc, 0);
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;

        // Four pending slots, then four in-order responses, then pop in order.
        for (int i = 0; i < 4; i++) begin
            clr();
            set_push(32'h1000 + 32'(4 * i), 1, 0, 0);
            cyc();
        end
        clr();
        chk("full_in_ready", in_ready, 0);
        chk("full_credit", req_credit, 0);
        for (int i = 0; i < 4; i++) begin
            clr();
            data_ok = 1;
            rdata = 32'h11 * (i + 1);
            cyc();
        end
        clr();
        chk("first_inst", out_inst, 32'h11);
        chk("first_pc", out_pc, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            clr();
            out_ready = 1;
            cyc();
        end
        drain();

        // Exception slot needs no response.
        clr();
        set_push(32'h1c000000, 0, 0, 0);
        in_has_exception = 1; in_ecode = 6'h08; in_esubcode = 9'h3;
        cyc();
        clr();
        chk("exc_out_valid", out_valid, 1);
        chk("exc_ecode", out_ecode, 6'h08);
        cyc();
        out_ready = 1;
        cyc();
        drain();

        // Flush with three pending and a simultaneous response; the next two are dropped.
        for (int i = 0; i < 3; i++) begin
            clr();
            set_push(32'h2000 + 32'(4 * i), 1, 0, 0);
            cyc();
        end
        clr();
        br_flush = 1; data_ok = 1; rdata = 32'h999;
        cyc();
        clr();
        chk("flush_credit", req_credit, DEPTH - 2);
        set_push(32'h4000, 1, 0, 0);
        data_ok = 1; rdata = 32'h111;
        cyc();
        clr();
        data_ok = 1; rdata = 32'h222;
        cyc();
        clr();
        data_ok = 1; rdata = 32'h333;
        cyc();
        clr();
        chk("flush_new_valid", out_valid, 1);
        chk("flush_new_inst", out_inst, 32'h333);
        cyc();
        drain();

        // Streaming through pointer wrap.
        for (int i = 0; i < 4; i++) begin
            clr();
            set_push(32'h3000 + 32'(4 * i), 0, 1, 32'hC0DE0000 + 32'(i));
            cyc();
        end
        for (int i = 4; i < 24; i++) begin
            clr();
            out_ready = 1;
            set_push(32'h3000 + 32'(4 * i), 0, 1, 32'hC0DE0000 + 32'(i));
            cyc();
        end
        drain();

        // Asynchronous reset with two pending slots and one response to discard.
        clr();
        set_push(32'h5000, 1, 0, 0);
        cyc();
        clr();
        ex_flush = 1;
        cyc();
        clr();
        set_push(32'h5004, 1, 0, 0);
        cyc();
        set_push(32'h5008, 1, 0, 0);
        cyc();
        clr();
        chk("pre_rst_credit", req_credit, 1);
        #2;
        resetn = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_credit", req_credit, DEPTH);
        chk("arst_out_pc", out_pc, 0);
        mq.delete();
        rq.delete();
        @(posedge clk);
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
        cyc();

        // Response aimed at a waiting head slot.
        clr();
        set_push(32'h6000, 1, 0, 0);
        cyc();
        clr();
        data_ok = 1; rdata = 32'hABCD;
        cyc();
        clr();
        chk("resp_head_inst", out_inst, 32'hABCD);
        cyc();
        drain();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int r;
            clr();
            in_valid = $urandom_range(0, 1);
            in_inst_valid = ($urandom_range(0, 9) < 3);
            in_has_exception = ($urandom_range(0, 9) == 0);
            in_req_sent = (rq.size() < DEPTH) && ($urandom_range(0, 9) < (in_inst_valid ? 2 : 9));
            if (!in_inst_valid && !in_has_exception && !in_req_sent) in_inst_valid = 1;
            in_pc = $urandom;
            in_inst = in_inst_valid ? $urandom : 32'h0;
            in_ecode = in_has_exception ? 6'($urandom) : 6'h0;
            in_esubcode = in_has_exception ? 9'($urandom) : 9'h0;
            data_ok = (rq.size() > 0) && ($urandom_range(0, 1) == 1);
            rdata = $urandom;
            r = $urandom_range(0, 39);
            br_flush = (r == 0); ex_flush = (r == 1); ertn_flush = (r == 2);
            out_ready = ($urandom_range(0, 9) < 6);
            cyc();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
